spi_controller: RTL and testbench
=================================

Name: spi_controller

Overview:
- SPI mode-0 controller (initiator) that issues 16-bit register frames to the register-file SPI peripheral on the same chip, or to an off-chip one through uio pins.
- Host logic submits one request at a time over a valid/ready handshake. The block serialises the request onto sclk/ncs/copi and returns the read byte captured from cipo.
- It is the transmitting end of the peripheral's receive protocol and lives inside the top-level wrapper.

Parameters:
- HALF_PERIOD, 2, number of clk cycles per sclk half-period (legal range 1..255).

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request this cycle
- req_write  in  1  1=write frame, 0=read frame
- req_addr  in  7  register address
- req_wdata  in  8  write data; ignored for reads, sent as 0x00
- rsp_valid  out  1  one-cycle pulse: frame complete
- rsp_rdata  out  8  last 8 bits captured from cipo in the frame; held until next rsp_valid
- busy  out  1  high from accept until rsp_valid inclusive
- sclk  out  1  SPI clock, idle low
- ncs  out  1  chip select, active low
- copi  out  1  controller-out data
- cipo  in  1  controller-in data; synchronised externally

Behaviour:
- Clock and reset: one clock (clk). rst_n is asynchronous and active-low.
- Reset values:
  - ncs=1, sclk=0, copi=0.
  - req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00.
  - State IDLE, all counters 0.
- Frame format, MSB first: bit15=req_write, bits14:8=req_addr, bits7:0=wdata.
  - Write request: wdata = req_wdata.
  - Read request: wdata = 0x00.
- Accept: req_valid && req_ready at a clk edge.
  - Frame is latched into tx shift register at that edge.
  - Later changes on the req_* inputs have no effect on the frame.
- req_ready is 1 only in IDLE and is registered.
  - req_valid while not ready is ignored; no queueing.
- States: IDLE -> LEAD -> HIGH <-> LOW -> GAP -> DONE -> IDLE.
  - LEAD: entered on accept. ncs=0, sclk=0, copi=frame[15]. Lasts HALF_PERIOD cycles.
  - HIGH: sclk=1 for HALF_PERIOD cycles. cipo is shifted into rx shift register (LSB in) on the edge entering HIGH.
  - LOW: sclk=0 for HALF_PERIOD cycles.
    - On the edge entering LOW, copi advances to the next frame bit, except after bit 0.
    - After bit 0, copi holds bit 0 through LOW and drops to 0 with ncs.
    - LOW after bit k (k>0) returns to HIGH for bit k-1.
    - LOW after bit 0 is the trailing hold, then go to GAP.
  - GAP: ncs=1, sclk=0, copi=0 for HALF_PERIOD cycles.
  - DONE: single cycle. rsp_valid=1 and rsp_rdata=rx[7:0]. Next cycle IDLE, req_ready=1, busy=0.
- Timing:
  - Exactly 16 sclk rising edges per frame.
  - ncs low for 33*HALF_PERIOD cycles, starting the cycle after accept.
  - Accept to rsp_valid = 34*HALF_PERIOD+1 cycles.
  - Minimum ncs-high time between frames = HALF_PERIOD+2 cycles.
- Counters:
  - Bit counter 4 bits, counting 15 down to 0. No wrap; the terminal count selects GAP.
  - Half-period counter width is $clog2(HALF_PERIOD+1).
- HALF_PERIOD=1: sclk toggles every clk cycle; same state sequence.
- Reset mid-frame: outputs go to reset values asynchronously (ncs=1 immediately).
  - No rsp_valid for the aborted frame.
  - rsp_rdata returns to 0x00.
- cipo during the first 8 bits is captured and discarded; only the last 8 bits appear in rsp_rdata.

Decomposition:
- Package spi_pkg:
  - FRAME_W=16, ADDR_W=7, DATA_W=8.
  - Frame bit positions: RW_BIT=15, ADDR_MSB=14, ADDR_LSB=8.
  - State enum spi_ctrl_state_t {IDLE, LEAD, HIGH, LOW, GAP, DONE}.
  - This package is shared with the peripheral.
- Sub-module spi_half_tick:
  - Parameterised down-counter emitting a one-cycle tick every HALF_PERIOD cycles while enabled.
  - Reloads when disabled.
  - The FSM advances phase on tick.

Test Plan:
- Reset: hold rst_n=0 with random inputs -> ncs=1, sclk=0, copi=0, req_ready=1, busy=0, rsp_valid=0, rsp_rdata=0x00.
- Write, HALF_PERIOD=2: write=1, addr=0x00, wdata=0xF0 -> copi sampled at 16 sclk rises reads 0x80F0; ncs low 66 cycles; rsp_valid exactly 69 cycles after accept.
- Read: write=0, addr=0x04, wdata=0xFF; bench model drives 0xA5 on cipo during bits 7..0 (changes after sclk falls) -> copi stream 0x0400; rsp_rdata=0xA5 with rsp_valid.
- Back-to-back: req_valid held high with two queued requests -> second accepted only when req_ready=1; ncs high >=4 cycles between frames; no missing or extra sclk edges.
- Abort: pulse rst_n low after the 5th sclk rise -> ncs=1 in the same cycle, no rsp_valid. A subsequent write addr=0x01, data=0x3C yields a clean 0x813C frame.
- Input stability: change req_addr/req_wdata every cycle after accept -> transmitted frame equals the values present at accept; HALF_PERIOD=1 variant repeats the write test with ncs low 33 cycles.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI register-frame definitions, used by the controller and by the peripheral.
// A frame is {rw, addr[6:0], data[7:0]} and is sent MSB first.
package spi_pkg;

   localparam int FRAME_W  = 16;
   localparam int ADDR_W   = 7;
   localparam int DATA_W   = 8;
   localparam int BIT_W    = 4;

   localparam int RW_BIT   = 15;
   localparam int ADDR_MSB = 14;
   localparam int ADDR_LSB = 8;

   typedef enum logic [2:0] {
      IDLE,
      LEAD,
      HIGH,
      LOW,
      GAP,
      DONE
   } spi_ctrl_state_t;

   // Read frames carry 0x00 in the data field regardless of the supplied data.
   function automatic logic [FRAME_W-1:0] build_frame(
      input logic              wr,
      input logic [ADDR_W-1:0] addr,
      input logic [DATA_W-1:0] wdata
   );
      logic [FRAME_W-1:0] f;
      f                    = '0;
      f[RW_BIT]            = wr;
      f[ADDR_MSB:ADDR_LSB] = addr;
      f[DATA_W-1:0]        = wr ? wdata : '0;
      return f;
   endfunction

endpackage

// File: rtl/spi_half_tick.sv
// Half-period timer: emits a one-cycle tick every HALF_PERIOD clk cycles while enabled.
// The count reloads whenever the timer is disabled, so every enabled phase starts fresh.
module spi_half_tick #(
   parameter int HALF_PERIOD = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic en,
   output logic tick
);

   localparam int            CW     = $clog2(HALF_PERIOD + 1);
   localparam logic [CW-1:0] RELOAD = CW'(HALF_PERIOD - 1);

   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else if (!en || (cnt_q == '0)) begin
         cnt_q <= RELOAD;
      end else begin
         cnt_q <= cnt_q - 1'b1;
      end
   end

   assign tick = en && (cnt_q == '0);

endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 initiator: takes one register request over valid/ready, shifts a 16-bit frame
// out on copi while sampling cipo, and returns the last captured byte with a rsp_valid pulse.
import spi_pkg::*;

module spi_controller #(
   parameter int HALF_PERIOD = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_write,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              busy,
   output logic              sclk,
   output logic              ncs,
   output logic              copi,
   input  logic              cipo
);

   // Handshake: a request is accepted on any clk edge where req_valid && req_ready.
   // req_ready is high only in IDLE, so there is never more than one frame in flight
   // and a request presented while busy simply waits; nothing is queued internally.

   spi_ctrl_state_t    state_q, state_d;
   logic [FRAME_W-1:0] tx_q, tx_d;
   logic [DATA_W-1:0]  rx_q, rx_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [DATA_W-1:0]  rdata_q;
   logic               ncs_q, sclk_q, copi_q;
   logic               ready_q, busy_q, rsp_valid_q;
   logic               tick;
   logic               timer_en;
   logic               active_d;

   assign timer_en = (state_q == LEAD) || (state_q == HIGH) ||
                     (state_q == LOW)  || (state_q == GAP);

   spi_half_tick #(
      .HALF_PERIOD (HALF_PERIOD)
   ) u_half_tick (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (timer_en),
      .tick  (tick)
   );

   always_comb begin
      state_d = state_q;
      tx_d    = tx_q;
      rx_d    = rx_q;
      bit_d   = bit_q;
      case (state_q)
         IDLE: begin
            if (req_valid) begin
               state_d = LEAD;
               tx_d    = build_frame(req_write, req_addr, req_wdata);
               bit_d   = BIT_W'(FRAME_W - 1);
            end
         end
         LEAD: begin
            if (tick) begin
               state_d = HIGH;
               rx_d    = {rx_q[DATA_W-2:0], cipo};
            end
         end
         HIGH: begin
            // After bit 0 the shifter stops so copi holds bit 0 through the trailing LOW.
            if (tick) begin
               state_d = LOW;
               if (bit_q != '0) tx_d = {tx_q[FRAME_W-2:0], 1'b0};
            end
         end
         LOW: begin
            if (tick) begin
               if (bit_q == '0) begin
                  state_d = GAP;
               end else begin
                  state_d = HIGH;
                  bit_d   = bit_q - 1'b1;
                  rx_d    = {rx_q[DATA_W-2:0], cipo};
               end
            end
         end
         GAP: begin
            if (tick) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign active_d = (state_d == LEAD) || (state_d == HIGH) || (state_d == LOW);

   // Pin-level outputs are registered from the next state so they never glitch.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         tx_q        <= '0;
         rx_q        <= '0;
         bit_q       <= '0;
         rdata_q     <= '0;
         ncs_q       <= 1'b1;
         sclk_q      <= 1'b0;
         copi_q      <= 1'b0;
         ready_q     <= 1'b1;
         busy_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         tx_q        <= tx_d;
         rx_q        <= rx_d;
         bit_q       <= bit_d;
         ncs_q       <= !active_d;
         sclk_q      <= (state_d == HIGH);
         copi_q      <= active_d && tx_d[FRAME_W-1];
         ready_q     <= (state_d == IDLE);
         busy_q      <= (state_d != IDLE);
         rsp_valid_q <= (state_d == DONE);
         if (state_d == DONE) rdata_q <= rx_d;
      end
   end

   assign req_ready = ready_q;
   assign busy      = busy_q;
   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rdata_q;
   assign sclk      = sclk_q;
   assign ncs       = ncs_q;
   assign copi      = copi_q;

endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: HALF_PERIOD=2 instance for most steps and a
// HALF_PERIOD=1 instance for the fast-clock variant; a bench-side cipo model supplies read bytes.
module tb_spi_controller;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       req_valid, req_valid1;
   logic       req_write;
   logic [6:0] req_addr;
   logic [7:0] req_wdata;
   logic       cipo;

   logic       req_ready, rsp_valid, busy, sclk, ncs, copi;
   logic [7:0] rsp_rdata;
   logic       req_ready1, rsp_valid1, busy1, sclk1, ncs1, copi1;
   logic [7:0] rsp_rdata1;

   int n_checks = 0;
   int n_fail   = 0;

   logic [15:0] exp_q[$];

   logic [15:0] f_copi;
   logic [7:0]  f_rdata;
   int          f_ncs_low, f_lat, f_rises;
   bit          f_got;

   always #5 clk = ~clk;

   spi_controller #(.HALF_PERIOD(2)) dut (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
      .sclk(sclk), .ncs(ncs), .copi(copi), .cipo(cipo)
   );

   spi_controller #(.HALF_PERIOD(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .req_valid(req_valid1), .req_ready(req_ready1),
      .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid1), .rsp_rdata(rsp_rdata1), .busy(busy1),
      .sclk(sclk1), .ncs(ncs1), .copi(copi1), .cipo(cipo)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Drives one request into the selected instance and follows it until rsp_valid.
   task automatic run_frame(input bit sel, input logic wr, input logic [6:0] addr,
                            input logic [7:0] wd, input logic [7:0] rbyte, input bit perturb);
      bit   acc, done, s, prev_s;
      int   n;
      f_copi = '0; f_rdata = '0; f_ncs_low = 0; f_lat = 0; f_rises = 0; f_got = 0;
      acc = 0;
      for (int i = 0; i < 100 && !acc; i++) begin
         @(negedge clk);
         if (sel ? req_ready1 : req_ready) acc = 1;
      end
      check("ready_before_request", 32'(acc), 32'd1);
      req_write = wr; req_addr = addr; req_wdata = wd;
      if (sel) req_valid1 = 1'b1; else req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0; req_valid1 = 1'b0;
      prev_s = 1'b0;
      done   = 0;
      n      = 0;
      while (!done && n < 200) begin
         @(negedge clk);
         n++;
         s = sel ? sclk1 : sclk;
         if (!(sel ? ncs1 : ncs)) f_ncs_low++;
         if (s && !prev_s) begin
            f_copi = {f_copi[14:0], (sel ? copi1 : copi)};
            f_rises++;
         end
         prev_s = s;
         if (!s) cipo = (f_rises >= 8 && f_rises < 16) ? rbyte[15 - f_rises] : 1'($urandom_range(0, 1));
         if (perturb) begin
            req_write = 1'($urandom_range(0, 1));
            req_addr  = 7'($urandom_range(0, 127));
            req_wdata = 8'($urandom_range(0, 255));
         end
         if (sel ? rsp_valid1 : rsp_valid) begin
            f_lat   = n;
            f_rdata = sel ? rsp_rdata1 : rsp_rdata;
            f_got   = 1;
            check("busy_at_rsp", 32'(sel ? busy1 : busy), 32'd1);
            done = 1;
         end
      end
      check("rsp_seen", 32'(f_got), 32'd1);
      @(negedge clk);
      check("rsp_single_pulse", 32'(sel ? rsp_valid1 : rsp_valid), 32'd0);
      check("ready_after_rsp", 32'(sel ? req_ready1 : req_ready), 32'd1);
      check("idle_after_rsp", 32'(sel ? busy1 : busy), 32'd0);
      check("rdata_held", 32'(sel ? rsp_rdata1 : rsp_rdata), 32'(f_rdata));
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit         pend;
      int         acc, rises, rsp_cnt, acc_at_first_rsp, hi_run, gap, ncs_low_cnt;
      bit         seen_low, prev_s;
      logic [31:0] bits_all;
      logic [7:0]  rd_a, rd_b;

      // Reset with random inputs.
      rst_n = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         req_valid  = 1'($urandom_range(0, 1));
         req_valid1 = 1'($urandom_range(0, 1));
         req_write  = 1'($urandom_range(0, 1));
         req_addr   = 7'($urandom_range(0, 127));
         req_wdata  = 8'($urandom_range(0, 255));
         cipo       = 1'($urandom_range(0, 1));
      end
      check("reset_ncs", 32'(ncs), 32'd1);
      check("reset_sclk", 32'(sclk), 32'd0);
      check("reset_copi", 32'(copi), 32'd0);
      check("reset_req_ready", 32'(req_ready), 32'd1);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_rsp_valid", 32'(rsp_valid), 32'd0);
      check("reset_rsp_rdata", 32'(rsp_rdata), 32'h00);
      check("reset_ncs_hp1", 32'(ncs1), 32'd1);
      req_valid = 1'b0; req_valid1 = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;

      // Write 0x00 <- 0xF0.
      exp_q.push_back(16'h80F0);
      run_frame(0, 1'b1, 7'h00, 8'hF0, 8'h3C, 0);
      check("wr_copi_frame", 32'(f_copi), 32'(exp_q.pop_front()));
      check("wr_sclk_rises", f_rises, 16);
      check("wr_ncs_low_cycles", f_ncs_low, 66);
      check("wr_latency", f_lat, 69);
      check("wr_rdata", 32'(f_rdata), 32'h3C);

      // Read 0x04; data field must go out as zero.
      exp_q.push_back(16'h0400);
      run_frame(0, 1'b0, 7'h04, 8'hFF, 8'hA5, 0);
      check("rd_copi_frame", 32'(f_copi), 32'(exp_q.pop_front()));
      check("rd_rdata", 32'(f_rdata), 32'hA5);
      check("rd_latency", f_lat, 69);

      // Inputs scrambled every cycle after accept.
      exp_q.push_back(16'hDA96);
      run_frame(0, 1'b1, 7'h5A, 8'h96, 8'h0F, 1);
      check("stable_copi_frame", 32'(f_copi), 32'(exp_q.pop_front()));
      check("stable_rdata", 32'(f_rdata), 32'h0F);
      check("stable_sclk_rises", f_rises, 16);

      // Back-to-back: valid held high across two requests.
      cipo = 1'b1;
      @(negedge clk);
      req_write = 1'b1; req_addr = 7'h12; req_wdata = 8'h34;
      req_valid = 1'b1;
      acc = 0; rises = 0; rsp_cnt = 0; acc_at_first_rsp = -1;
      hi_run = 0; gap = -1; seen_low = 0; prev_s = 1'b0; bits_all = '0;
      rd_a = '0; rd_b = '0;
      for (int c = 0; c < 300 && rsp_cnt < 2; c++) begin
         if (c != 0) @(negedge clk);
         if (sclk && !prev_s) begin
            bits_all = {bits_all[30:0], copi};
            rises++;
         end
         prev_s = sclk;
         if (!ncs) begin
            if (seen_low && hi_run > 0 && gap < 0) gap = hi_run;
            seen_low = 1;
            hi_run   = 0;
         end else if (seen_low) begin
            hi_run++;
         end
         if (rsp_valid) begin
            rsp_cnt++;
            if (rsp_cnt == 1) begin
               acc_at_first_rsp = acc;
               rd_a = rsp_rdata;
            end else begin
               rd_b = rsp_rdata;
            end
         end
         pend = req_ready && req_valid;
         @(posedge clk);
         #1;
         if (pend) begin
            acc++;
            if (acc == 1) begin
               req_write = 1'b0; req_addr = 7'h7F; req_wdata = 8'h55;
            end else begin
               req_valid = 1'b0;
            end
         end
      end
      req_valid = 1'b0;
      check("b2b_accepts", acc, 2);
      check("b2b_single_inflight", acc_at_first_rsp, 1);
      check("b2b_rsp_count", rsp_cnt, 2);
      check("b2b_sclk_rises", rises, 32);
      check("b2b_copi_frames", bits_all, 32'h9234_7F00);
      check("b2b_ncs_gap_min", 32'(gap >= 4), 32'd1);
      check("b2b_rdata_a", 32'(rd_a), 32'hFF);
      check("b2b_rdata_b", 32'(rd_b), 32'hFF);

      // Abort with reset after the 5th sclk rise.
      @(negedge clk);
      req_write = 1'b1; req_addr = 7'h33; req_wdata = 8'h77;
      req_valid = 1'b1;
      @(posedge clk);
      #1;
      req_valid = 1'b0;
      rises = 0; prev_s = 1'b0;
      for (int c = 0; c < 100 && rises < 5; c++) begin
         @(negedge clk);
         if (sclk && !prev_s) rises++;
         prev_s = sclk;
      end
      check("abort_reached_rise5", rises, 5);
      rst_n = 1'b0;
      #1;
      check("abort_ncs", 32'(ncs), 32'd1);
      check("abort_sclk", 32'(sclk), 32'd0);
      check("abort_copi", 32'(copi), 32'd0);
      check("abort_rsp_rdata", 32'(rsp_rdata), 32'h00);
      check("abort_busy", 32'(busy), 32'd0);
      check("abort_req_ready", 32'(req_ready), 32'd1);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_cnt = 0; ncs_low_cnt = 0;
      for (int c = 0; c < 80; c++) begin
         @(negedge clk);
         if (rsp_valid) rsp_cnt++;
         if (!ncs) ncs_low_cnt++;
      end
      check("abort_no_rsp", rsp_cnt, 0);
      check("abort_ncs_stays_high", ncs_low_cnt, 0);

      exp_q.push_back(16'h813C);
      run_frame(0, 1'b1, 7'h01, 8'h3C, 8'hC3, 0);
      check("post_abort_copi_frame", 32'(f_copi), 32'(exp_q.pop_front()));
      check("post_abort_latency", f_lat, 69);
      check("post_abort_ncs_low", f_ncs_low, 66);
      check("post_abort_rdata", 32'(f_rdata), 32'hC3);

      // HALF_PERIOD=1 instance repeats the write.
      exp_q.push_back(16'h80F0);
      run_frame(1, 1'b1, 7'h00, 8'hF0, 8'h5A, 0);
      check("hp1_copi_frame", 32'(f_copi), 32'(exp_q.pop_front()));
      check("hp1_sclk_rises", f_rises, 16);
      check("hp1_ncs_low_cycles", f_ncs_low, 33);
      check("hp1_latency", f_lat, 35);
      check("hp1_rdata", 32'(f_rdata), 32'h5A);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
